// File: rtl/gen_pair_consumer.sv
// gen_pair_consumer: launches an upstream two-output generator, absorbs
// its (_out0, _out1) tuples and reduces them to a signed dot product.
//
// Ports:
//   _clock, _reset_n        clock, synchronous active-low reset
//   _start                  host run request (sampled in IDLE only)
//   _gen_start              one-cycle launch pulse to the generator
//   _in0/_in1/_in_valid     yielded tuple and its valid
//   _in_ready               tuple can be accepted (COLLECT only)
//   _in_done                generator done level
//   _sum/_count             dot product and accepted-tuple count
//   _overflow/_truncated    sticky accumulate overflow, MAX_COUNT stop
//   _out_valid/_out_ready   result handshake
//   _busy                   any state other than IDLE
module gen_pair_consumer #(
   parameter int ACC_WIDTH = 64,
   parameter int CNT_WIDTH = 16,
   parameter int MAX_COUNT = 65535
) (
   input  logic                        _clock,
   input  logic                        _reset_n,
   input  logic                        _start,
   output logic                        _gen_start,
   input  logic signed [31:0]          _in0,
   input  logic signed [31:0]          _in1,
   input  logic                        _in_valid,
   output logic                        _in_ready,
   input  logic                        _in_done,
   output logic signed [ACC_WIDTH-1:0] _sum,
   output logic [CNT_WIDTH-1:0]        _count,
   output logic                        _overflow,
   output logic                        _truncated,
   output logic                        _out_valid,
   input  logic                        _out_ready,
   output logic                        _busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LAUNCH  = 2'd1,
      COLLECT = 2'd2,
      REPORT  = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] MAX_C = CNT_WIDTH'(MAX_COUNT);

   state_t state_q;
   state_t state_nxt;

   logic signed [ACC_WIDTH-1:0] sum_nxt;
   logic [CNT_WIDTH-1:0]        count_nxt;
   logic                        ovf_nxt;
   logic                        trunc_nxt;

   logic signed [63:0]          prod;
   logic signed [ACC_WIDTH-1:0] prod_ext;
   logic signed [ACC_WIDTH-1:0] acc_add;
   logic                        add_ovf;
   logic                        xfer;

   // Full-width product, sign-extended by the signed size cast.
   assign prod     = 64'($signed(_in0) * $signed(_in1));
   assign prod_ext = ACC_WIDTH'(prod);
   assign acc_add  = _sum + prod_ext;

   // Overflow: both addends share a sign that the result does not.
   assign add_ovf = (_sum[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1])
                 && (acc_add[ACC_WIDTH-1] != _sum[ACC_WIDTH-1]);

   // _in_ready is only ever high in COLLECT.
   assign xfer = _in_valid & _in_ready;

   always_comb begin
      state_nxt = state_q;
      sum_nxt   = _sum;
      count_nxt = _count;
      ovf_nxt   = _overflow;
      trunc_nxt = _truncated;
      case (state_q)
         IDLE: begin
            if (_start) begin
               state_nxt = LAUNCH;
               sum_nxt   = '0;
               count_nxt = '0;
               ovf_nxt   = 1'b0;
               trunc_nxt = 1'b0;
            end
         end
         LAUNCH: begin
            // _in_done may still be stale from the previous run here.
            state_nxt = COLLECT;
         end
         COLLECT: begin
            if (xfer) begin
               sum_nxt   = acc_add;
               count_nxt = _count + 1'b1;
               if (add_ovf) ovf_nxt = 1'b1;
            end
            if (_in_done) begin
               state_nxt = REPORT;
            end else if (count_nxt == MAX_C) begin
               state_nxt = REPORT;
               trunc_nxt = 1'b1;
            end
         end
         REPORT: begin
            if (_out_valid && _out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next-state values so they line
   // up with the state they describe.
   always_ff @(posedge _clock) begin
      if (!_reset_n) begin
         state_q    <= IDLE;
         _sum       <= '0;
         _count     <= '0;
         _overflow  <= 1'b0;
         _truncated <= 1'b0;
         _gen_start <= 1'b0;
         _in_ready  <= 1'b0;
         _out_valid <= 1'b0;
         _busy      <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         _sum       <= sum_nxt;
         _count     <= count_nxt;
         _overflow  <= ovf_nxt;
         _truncated <= trunc_nxt;
         _gen_start <= (state_nxt == LAUNCH);
         _in_ready  <= (state_nxt == COLLECT) && (count_nxt < MAX_C);
         _out_valid <= (state_nxt == REPORT);
         _busy      <= (state_nxt != IDLE);
      end
   end

endmodule

// File: tb/tb_gen_pair_consumer.sv
// tb_gen_pair_consumer: directed bench for gen_pair_consumer
// with MAX_COUNT=4 so the truncation path is reachable quickly.
module tb_gen_pair_consumer;

   logic               clk;
   logic               rst_n;
   logic               start;
   logic               gen_start;
   logic signed [31:0] in0;
   logic signed [31:0] in1;
   logic               in_valid;
   logic               in_ready;
   logic               in_done;
   logic signed [63:0] sum;
   logic [15:0]        count;
   logic               ovf;
   logic               trunc;
   logic               out_valid;
   logic               out_ready;
   logic               busy;

   int total = 0;
   int bad   = 0;

   gen_pair_consumer #(
      .ACC_WIDTH(64),
      .CNT_WIDTH(16),
      .MAX_COUNT(4)
   ) dut (
      ._clock    (clk),
      ._reset_n  (rst_n),
      ._start    (start),
      ._gen_start(gen_start),
      ._in0      (in0),
      ._in1      (in1),
      ._in_valid (in_valid),
      ._in_ready (in_ready),
      ._in_done  (in_done),
      ._sum      (sum),
      ._count    (count),
      ._overflow (ovf),
      ._truncated(trunc),
      ._out_valid(out_valid),
      ._out_ready(out_ready),
      ._busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // flags = {gen_start, in_ready, ovf, trunc, out_valid, busy}
   function automatic logic [63:0] flags();
      return {58'd0, gen_start, in_ready, ovf, trunc, out_valid, busy};
   endfunction

   task automatic launch(input string tag);
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk({tag, "_launch"}, flags(), 64'b100001);
      cyc();
      chk({tag, "_collect"}, flags(), 64'b010001);
      chk({tag, "_clr_cnt"}, 64'(count), 64'd0);
   endtask

   task automatic ack();
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      chk("ack_idle", flags() & 64'b110011, 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; in0 = '0; in1 = '0;
      in_valid = 1'b0; in_done = 1'b0; out_ready = 1'b0;
      cyc();
      cyc();
      chk("rst_flags", flags(), 64'd0);
      chk("rst_sum", sum, 64'd0);
      chk("rst_cnt", 64'(count), 64'd0);
      rst_n = 1'b1;
      cyc();
      chk("idle", flags(), 64'd0);

      // (3,4),(-5,6) -> -18
      launch("t1");
      in0 = 3; in1 = 4; in_valid = 1'b1;
      cyc();
      in0 = -5; in1 = 6;
      cyc();
      chk("t1_pre_done", flags(), 64'b010001);
      in_valid = 1'b0; in_done = 1'b1;
      cyc();
      in_done = 1'b0;
      chk("t1_flags", flags(), 64'b000011);
      chk("t1_sum", sum, -64'sd18);
      chk("t1_cnt", 64'(count), 64'd2);
      ack();
      chk("t1_hold", sum, -64'sd18);

      // stale done held through LAUNCH, zero-tuple run
      in_done = 1'b1;
      cyc();
      chk("t2_idle", flags(), 64'd0);
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("t2_launch", flags(), 64'b100001);
      cyc();
      chk("t2_no_early", flags(), 64'b010001);
      cyc();
      in_done = 1'b0;
      chk("t2_flags", flags(), 64'b000011);
      chk("t2_sum", sum, 64'd0);
      chk("t2_cnt", 64'(count), 64'd0);
      ack();

      // 6 tuples of (1,1), done late -> truncated at 4
      launch("t3");
      in0 = 1; in1 = 1; in_valid = 1'b1;
      cyc(); cyc(); cyc();
      chk("t3_cnt3", 64'(count), 64'd3);
      chk("t3_rdy3", 64'(in_ready), 64'd1);
      cyc();
      chk("t3_flags", flags(), 64'b000111);
      chk("t3_cnt", 64'(count), 64'd4);
      chk("t3_sum", sum, 64'd4);
      cyc(); cyc();
      chk("t3_drop_cnt", 64'(count), 64'd4);
      chk("t3_drop_sum", sum, 64'd4);
      in_valid = 1'b0; in_done = 1'b1;
      cyc();
      in_done = 1'b0;
      chk("t3_rep_hold", flags(), 64'b000111);
      ack();

      // done together with the 4th transfer -> not truncated
      launch("t4");
      in0 = 1; in1 = 1; in_valid = 1'b1;
      cyc(); cyc(); cyc();
      in_done = 1'b1;
      cyc();
      in_valid = 1'b0; in_done = 1'b0;
      chk("t4_flags", flags(), 64'b000011);
      chk("t4_cnt", 64'(count), 64'd4);
      chk("t4_sum", sum, 64'd4);
      ack();

      // overflow: two (-2^31)^2 wrap to 0x8000...
      launch("t5");
      in0 = 32'sh80000000; in1 = 32'sh80000000; in_valid = 1'b1;
      cyc();
      chk("t5_sum1", sum, 64'h4000000000000000);
      chk("t5_ovf1", 64'(ovf), 64'd0);
      in_done = 1'b1;
      cyc();
      in_valid = 1'b0; in_done = 1'b0;
      chk("t5_flags", flags(), 64'b001011);
      chk("t5_sum", sum, 64'h8000000000000000);
      chk("t5_cnt", 64'(count), 64'd2);

      // backpressure with _start pulsed in REPORT
      start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("bp_flags", flags(), 64'b001011);
         chk("bp_sum", sum, 64'h8000000000000000);
         chk("bp_cnt", 64'(count), 64'd2);
      end
      start = 1'b0;
      ack();
      cyc();
      chk("bp_no_queue", flags() & 64'b110011, 64'd0);
      chk("bp_idle_sum", sum, 64'h8000000000000000);

      // reset mid-COLLECT after 3 transfers
      launch("t6");
      in0 = 5; in1 = 7; in_valid = 1'b1;
      cyc(); cyc(); cyc();
      chk("t6_cnt3", 64'(count), 64'd3);
      chk("t6_sum3", sum, 64'd105);
      rst_n = 1'b0; in_valid = 1'b0;
      cyc();
      rst_n = 1'b1;
      chk("t6_rst_flags", flags(), 64'd0);
      chk("t6_rst_sum", sum, 64'd0);
      chk("t6_rst_cnt", 64'(count), 64'd0);
      launch("t7");
      in0 = 2; in1 = 2; in_valid = 1'b1; in_done = 1'b1;
      cyc();
      in_valid = 1'b0; in_done = 1'b0;
      chk("t7_flags", flags(), 64'b000011);
      chk("t7_sum", sum, 64'd4);
      chk("t7_cnt", 64'(count), 64'd1);
      ack();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
